imem_loader: RTL

Writable instruction memory with a byte-stream loader. It replaces the fixed-content instruction ROM when the program must be downloaded at run time, e.g. from a UART receiver. It accepts a length-prefixed little-endian byte stream and writes whole words into a DEPTH-entry RAM. It holds the processor in reset until the load completes, then serves the same combinational read port the processor already uses for instruction fetch.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_ram.sv | 24 ++
 rtl/imem_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and loader state type for the instruction memory loader
package imem_pkg;

    localparam int N              = 32;
    localparam int DEPTH          = 64;
    localparam int AW             = 6;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LOAD,
        DONE
    } imem_ld_state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x N instruction RAM, synchronous write, combinational read
module imem_ram
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    // No reset: contents are hidden by the word-count gating in the loader.
    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader in front of the instruction RAM
module imem_loader
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_reset,
    output logic [AW:0]   word_count,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q
);

    localparam logic [7:0] DEPTH_B   = 8'(DEPTH);
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    imem_ld_state_t state, state_next;
    logic [AW:0]    word_len;
    logic [1:0]     byte_idx;
    logic [23:0]    partial;
    logic           accept;
    logic           we;
    logic           start_ok;
    logic [AW:0]    count_inc;
    logic [N-1:0]   rdata;

    assign rx_ready  = (state == HDR) || (state == LOAD);
    assign busy      = rx_ready;
    assign done      = (state == DONE);
    assign cpu_reset = !done;
    assign accept    = rx_valid && rx_ready;
    assign we        = accept && (state == LOAD) && (byte_idx == LAST_LANE);
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign count_inc = word_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = HDR;
            HDR: begin
                if (accept) begin
                    if (rx_data == 8'd0 || rx_data > DEPTH_B) state_next = DONE;
                    else                                       state_next = LOAD;
                end
            end
            LOAD: if (we && count_inc == word_len) state_next = DONE;
            DONE: if (start) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
            word_len   <= '0;
            byte_idx   <= '0;
            partial    <= '0;
            err        <= 1'b0;
        end else if (start_ok) begin
            word_count <= '0;
            byte_idx   <= '0;
            err        <= 1'b0;
        end else if (accept && state == HDR) begin
            // An oversize length is never used as a bound, so truncation is harmless.
            word_len <= rx_data[AW:0];
            err      <= (rx_data > DEPTH_B);
        end else if (accept && state == LOAD) begin
            if (byte_idx == LAST_LANE) begin
                word_count <= count_inc;
                byte_idx   <= '0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    partial[7:0]   <= rx_data;
                    2'd1:    partial[15:8]  <= rx_data;
                    default: partial[23:16] <= rx_data;
                endcase
            end
        end
    end

    imem_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_count[AW-1:0]),
        .wdata ({rx_data, partial}),
        .raddr (addr),
        .rdata (rdata)
    );

    assign q = ({1'b0, addr} < word_count) ? rdata : '0;

endmodule
